// File: rtl/lime_output_port_if.sv
// Valid/ready handshake bundle between the output port and its consumer.
interface lime_output_port_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lime_output_port.sv
// Buffered core output port: change detector feeding a small FIFO drained over
// valid/ready, with a sticky overflow flag for values dropped while full.
module lime_output_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         proc_output,
  lime_output_port_if.master       port,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_value;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_req;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  always_comb begin
    push_req = (proc_output != last_value);
    full     = (level == FULL_LEVEL);
    pop      = port.out_valid && port.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      last_value <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
    end else begin
      last_value <= proc_output;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (Reset && push_ok) mem[wr_ptr] <= proc_output;
  end

  assign port.out_data  = mem[rd_ptr];
  assign port.out_valid = (level != '0);
endmodule

// File: tb/tb_lime_output_port.sv
// Bench for lime_output_port: table vectors with hand-derived level/overflow plus
// a queue scoreboard checking data order at every pop.
module tb_lime_output_port;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             CLK;
  logic             Reset;
  logic [WIDTH-1:0] proc_output;
  logic [2:0]       level;
  logic             overflow;
  logic             clear_overflow;

  lime_output_port_if #(.WIDTH(WIDTH)) bus ();

  lime_output_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .proc_output    (proc_output),
    .port           (bus),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] v;
    logic        rdy;
    logic        clr;
    int          lvl;
    logic        ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  logic [15:0] m_last;
  logic        m_ovf;
  int          n_cmp;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] v, input logic rdy, input logic clr,
                     input int lvl, input logic ovf);
    vec_t r;
    r.v = v; r.rdy = rdy; r.clr = clr; r.lvl = lvl; r.ovf = ovf;
    vecs.push_back(r);
  endtask

  // Called at a falling edge; drives inputs, checks the head, advances one edge.
  task automatic cycle(input logic [15:0] v, input logic rdy, input logic clr);
    int  pre;
    logic pop_m, push_m, req_m;
    proc_output = v; bus.out_ready = rdy; clear_overflow = clr;
    #1;
    pre = sb.size();
    chk("out_valid", 32'(bus.out_valid), 32'(pre != 0));
    if (pre != 0) chk("out_data", 32'(bus.out_data), 32'(sb[0]));
    pop_m  = (pre != 0) && rdy;
    req_m  = (v != m_last);
    push_m = req_m && (pre < DEPTH || pop_m);
    if (pop_m)  void'(sb.pop_front());
    if (push_m) sb.push_back(v);
    if (req_m && !push_m) m_ovf = 1'b1;
    else if (clr)         m_ovf = 1'b0;
    m_last = v;
    @(posedge CLK); #1;
    chk("level", 32'(level), 32'(sb.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    @(negedge CLK);
  endtask

  // Called at a falling edge; asserts reset between edges, releases at next falling edge.
  task automatic reset_pulse();
    #2 Reset = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    sb.delete(); m_last = '0; m_ovf = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_last = '0; m_ovf = 1'b0;
    Reset = 1'b1; proc_output = '0; bus.out_ready = 1'b0; clear_overflow = 1'b0;

    // Single value with stall, then one-cycle release.
    add(16'h1234, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) add(16'h1234, 0, 0, 1, 0);
    add(16'h1234, 1, 0, 0, 0);
    // Overflow: 5 is dropped, drain 1..4, then clear.
    add(16'd1, 0, 0, 1, 0); add(16'd2, 0, 0, 2, 0); add(16'd3, 0, 0, 3, 0);
    add(16'd4, 0, 0, 4, 0); add(16'd5, 0, 0, 4, 1);
    add(16'd5, 1, 0, 3, 1); add(16'd5, 1, 0, 2, 1); add(16'd5, 1, 0, 1, 1);
    add(16'd5, 1, 0, 0, 1); add(16'd5, 0, 1, 0, 0);
    // Full with simultaneous push/pop, drain 11..14.
    add(16'd10, 0, 0, 1, 0); add(16'd11, 0, 0, 2, 0); add(16'd12, 0, 0, 3, 0);
    add(16'd13, 0, 0, 4, 0); add(16'd14, 1, 0, 4, 0);
    add(16'd14, 1, 0, 3, 0); add(16'd14, 1, 0, 2, 0); add(16'd14, 1, 0, 1, 0);
    add(16'd14, 1, 0, 0, 0);

    // Asynchronous reset with no clock edge yet.
    #2 Reset = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge CLK);
    Reset = 1'b1;

    for (int i = 0; i < 10; i++) cycle(16'h0000, 0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
    end

    // Full FIFO sustained push+pop across three pointer laps, then drain.
    for (int i = 0; i < 4; i++) cycle(16'(200 + i), 0, 0);
    for (int i = 0; i < 12; i++) cycle(16'(300 + i), 1, 0);
    chk("lap_level", 32'(level), 32'd4);
    chk("lap_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) cycle(16'(311), 1, 0);
    chk("lap_empty", 32'(level), 32'd0);

    // Repeat suppression.
    for (int i = 0; i < 20; i++) cycle(16'hBEEF, 0, 0);
    chk("hold_level", 32'(level), 32'd1);
    cycle(16'h0001, 0, 0);
    cycle(16'hBEEF, 0, 0);
    chk("repeat_level", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) cycle(16'hBEEF, 1, 0);
    chk("repeat_empty", 32'(level), 32'd0);

    // Reset mid-operation with level 3 and overflow set.
    for (int i = 1; i <= 5; i++) cycle(16'(i), 0, 0);
    cycle(16'd5, 1, 0);
    chk("pre_rst_level", 32'(level), 32'd3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    reset_pulse();
    cycle(16'h00AA, 0, 0);
    chk("post_rst_level", 32'(level), 32'd1);
    chk("post_rst_data", 32'(bus.out_data), 32'h00AA);
    cycle(16'h00AA, 1, 0);
    chk("post_rst_empty", 32'(level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
